// File: rtl/cart_pkg.sv
// Shared types, widths and arithmetic helpers for the cart checkout block.
package cart_pkg;

    localparam int NUM_SLOTS = 5;
    localparam int PRICE_W   = 16;
    localparam int QTY_W     = 8;
    localparam int TOTAL_W   = 32;
    localparam int IDX_W     = 3;
    localparam int CNT_W     = 3;
    localparam int RATE_W    = 8;
    localparam int PROD_W    = PRICE_W + QTY_W;
    localparam int TAX_IW    = TOTAL_W + RATE_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        MULT  = 3'd2,
        TAX   = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Tax in 1/256 units; the 40-bit product keeps every bit before truncation.
    function automatic logic [TOTAL_W-1:0] calc_tax(
        input logic [TOTAL_W-1:0] acc,
        input logic [RATE_W-1:0]  rate
    );
        logic [TAX_IW-1:0] prod;
        prod = TAX_IW'(acc) * TAX_IW'(rate);
        return prod[TAX_IW-1:RATE_W];
    endfunction

    // Grand total with an optional discount, clamped at zero instead of wrapping.
    function automatic logic [TOTAL_W-1:0] calc_grand(
        input logic [TOTAL_W-1:0] acc,
        input logic [TOTAL_W-1:0] tax,
        input logic [TOTAL_W-1:0] threshold,
        input logic [PRICE_W-1:0] discount
    );
        logic [TOTAL_W-1:0] sum;
        logic [TOTAL_W-1:0] disc;
        sum  = acc + tax;
        disc = TOTAL_W'(discount);
        if (threshold != '0 && acc >= threshold) begin
            return (sum >= disc) ? (sum - disc) : '0;
        end
        return sum;
    endfunction

endpackage

// File: rtl/cart_checkout_ctrl_item_mult.sv
// CartItem multiplier: price times quantity for one slot, purely combinational.
module cart_checkout_ctrl_item_mult
    import cart_pkg::*;
(
    input  logic [PRICE_W-1:0] price_i,
    input  logic [QTY_W-1:0]   qty_i,
    output logic [PROD_W-1:0]  product_o
);

    // Full-width product; 16x8 bits never overflows 24 bits.
    always_comb begin
        product_o = PROD_W'(price_i) * PROD_W'(qty_i);
    end

endmodule

// File: rtl/cart_checkout_ctrl.sv
// Checkout sequencer: walks the five cart slots, accumulates price x qty,
// applies tax and discount, and publishes the results with a done pulse.
//
// state | meaning
// IDLE  | waiting for start; results hold the last completed pass
// FETCH | slot_idx drives slot k, price/qty captured
// MULT  | product of slot k added to the accumulator when occupied
// TAX   | tax and grand total computed, results loaded on exit
// DONE  | one-cycle done pulse, back to IDLE
module cart_checkout_ctrl
    import cart_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [RATE_W-1:0]  tax_rate,
    input  logic [TOTAL_W-1:0] disc_threshold,
    input  logic [PRICE_W-1:0] disc_amount,
    output logic [IDX_W-1:0]   slot_idx,
    input  logic [PRICE_W-1:0] slot_price,
    input  logic [QTY_W-1:0]   slot_qty,
    output logic               busy,
    output logic               lock,
    output logic               done,
    output logic [TOTAL_W-1:0] subtotal,
    output logic [TOTAL_W-1:0] tax,
    output logic [TOTAL_W-1:0] grand_total,
    output logic [CNT_W-1:0]   item_count
);

    state_e             state_q;
    logic [IDX_W-1:0]   slot_q;
    logic [RATE_W-1:0]  rate_q;
    logic [TOTAL_W-1:0] thr_q;
    logic [PRICE_W-1:0] damt_q;
    logic [PRICE_W-1:0] price_q;
    logic [QTY_W-1:0]   qty_q;
    logic [TOTAL_W-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [TOTAL_W-1:0] subtotal_q;
    logic [TOTAL_W-1:0] tax_q;
    logic [TOTAL_W-1:0] grand_q;
    logic [CNT_W-1:0]   count_q;

    logic [PROD_W-1:0]  prod;
    logic [TOTAL_W-1:0] acc_d;
    logic [TOTAL_W-1:0] tax_d;
    logic [TOTAL_W-1:0] grand_d;

    // One multiplier shared by every slot; its operands are the captured price/qty.
    cart_checkout_ctrl_item_mult u_item_mult (
        .price_i   (price_q),
        .qty_i     (qty_q),
        .product_o (prod)
    );

    // Next accumulator value and the end-of-pass arithmetic.
    always_comb begin
        acc_d   = acc_q + TOTAL_W'(prod);
        tax_d   = calc_tax(acc_q, rate_q);
        grand_d = calc_grand(acc_q, tax_d, thr_q, damt_q);
    end

    // Sequencer with registered outputs; abort only bites while a pass is running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            rate_q     <= '0;
            thr_q      <= '0;
            damt_q     <= '0;
            price_q    <= '0;
            qty_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            subtotal_q <= '0;
            tax_q      <= '0;
            grand_q    <= '0;
            count_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        rate_q  <= tax_rate;
                        thr_q   <= disc_threshold;
                        damt_q  <= disc_amount;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        slot_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (abort) begin
                        slot_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        price_q <= slot_price;
                        qty_q   <= slot_qty;
                        state_q <= MULT;
                    end
                end
                MULT: begin
                    if (abort) begin
                        slot_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        if (price_q != '0) begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (slot_q == IDX_W'(NUM_SLOTS - 1)) begin
                            slot_q  <= '0;
                            state_q <= TAX;
                        end else begin
                            slot_q  <= slot_q + IDX_W'(1);
                            state_q <= FETCH;
                        end
                    end
                end
                TAX: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        subtotal_q <= acc_q;
                        tax_q      <= tax_d;
                        grand_q    <= grand_d;
                        count_q    <= cnt_q;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    slot_q  <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign slot_idx    = slot_q;
    assign busy        = busy_q;
    assign lock        = busy_q;
    assign done        = done_q;
    assign subtotal    = subtotal_q;
    assign tax         = tax_q;
    assign grand_total = grand_q;
    assign item_count  = count_q;

endmodule
